// File: rtl/obi_traffic_gen.sv
// OBI master traffic generator: writes, reads back and compares a block of
// pattern words, keeping up to MAX_OUTSTANDING transactions in flight.
module obi_traffic_gen #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    NUM_WORDS       = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter logic [31:0]           SEED            = 32'hDEADBEEF,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [1:0]                        mode_i,
  input  logic [1:0]                        pattern_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic [$clog2(NUM_WORDS+1)-1:0]    err_count_o,
  output logic [ADDR_WIDTH-1:0]             first_err_addr_o,
  output logic                              obi_req_o,
  input  logic                              obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]             obi_addr_o,
  output logic                              obi_we_o,
  output logic [DATA_WIDTH/8-1:0]           obi_be_o,
  output logic [DATA_WIDTH-1:0]             obi_wdata_o,
  input  logic                              obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             obi_rdata_i
);

  localparam int CNT_W = $clog2(NUM_WORDS+1);
  localparam int BE_W  = DATA_WIDTH/8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [1:0]              pattern_q, pattern_d;
  logic [CNT_W-1:0]        issued_q, issued_d;
  logic [CNT_W-1:0]        resp_q, resp_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    pass_q, pass_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    active;
  logic                    req;
  logic                    hs;
  logic                    rsp;
  logic                    phase_done;
  logic                    mismatch;
  logic [CNT_W-1:0]        outstanding;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   exp_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [DATA_WIDTH-1:0]   exp_data;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BE_W);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat_data(input logic [1:0]            pat,
                                                      input logic [CNT_W-1:0]      idx,
                                                      input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] seed_w;
    seed_w = DATA_WIDTH'(SEED);
    case (pat)
      2'd0:    return seed_w;
      2'd1:    return seed_w + DATA_WIDTH'(idx);
      2'd2:    return seed_w ^ DATA_WIDTH'(addr);
      default: return ~seed_w;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(NUM_WORDS)) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Both counters are registered, so the in-flight count never reacts
  // combinationally to the current cycle's grant or response.
  assign active      = (state_q == S_WRITE) || (state_q == S_READ);
  assign outstanding = issued_q - resp_q;
  assign req         = active && (issued_q < CNT_W'(NUM_WORDS)) &&
                       (int'(outstanding) < MAX_OUTSTANDING);
  assign hs          = req && obi_gnt_i;
  assign rsp         = active && obi_rvalid_i && (outstanding != '0);
  assign phase_done  = active && (issued_q == CNT_W'(NUM_WORDS)) &&
                       (resp_q == CNT_W'(NUM_WORDS));
  assign cur_addr    = word_addr(issued_q);
  assign exp_addr    = word_addr(resp_q);
  assign cur_data    = pat_data(pattern_q, issued_q, cur_addr);
  assign exp_data    = pat_data(pattern_q, resp_q, exp_addr);
  assign mismatch    = rsp && (state_q == S_READ) && (obi_rdata_i != exp_data);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    issued_d  = issued_q;
    resp_d    = resp_q;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          pattern_d = pattern_i;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          issued_d  = '0;
          resp_d    = '0;
          state_d   = (mode_i == 2'd1) ? S_READ : S_WRITE;
        end
      end
      S_WRITE, S_READ: begin
        if (hs) issued_d = issued_q + CNT_W'(1);
        if (rsp) resp_d = resp_q + CNT_W'(1);
        if (mismatch) begin
          err_d = sat_inc(err_q);
          if (err_q == '0) first_d = exp_addr;
        end
        // Phase boundary: one idle bus cycle while the counters clear.
        if (phase_done) begin
          issued_d = '0;
          resp_d   = '0;
          if ((state_q == S_WRITE) && (mode_q != 2'd0)) begin
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_q == '0);
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      pattern_q <= 2'd0;
      issued_q  <= '0;
      resp_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      issued_q  <= issued_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Bus outputs decode registered state only, so they hold until the handshake.
  assign obi_req_o        = req;
  assign obi_we_o         = req && (state_q == S_WRITE);
  assign obi_addr_o       = req ? cur_addr : '0;
  assign obi_wdata_o      = (req && (state_q == S_WRITE)) ? cur_data : '0;
  assign obi_be_o         = '1;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_obi_traffic_gen.sv
// Directed bench for obi_traffic_gen: a scoreboard of expected bus requests,
// an in-order memory slave, and a second instance with one transaction in flight.
module tb_obi_traffic_gen;

  localparam int          N    = 8;
  localparam logic [31:0] SEED = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_busy, a_done, a_pass, a_req, a_gnt, a_we, a_rvalid;
  logic [1:0]  a_mode, a_pat;
  logic [3:0]  a_err, a_be;
  logic [31:0] a_first, a_addr, a_wdata, a_rdata;
  logic        b_start, b_busy, b_done, b_pass, b_req, b_gnt, b_we, b_rvalid;
  logic [1:0]  b_mode, b_pat;
  logic [3:0]  b_err, b_be;
  logic [31:0] b_first, b_addr, b_wdata, b_rdata;

  obi_traffic_gen #(.NUM_WORDS(N), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .mode_i(a_mode), .pattern_i(a_pat),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_count_o(a_err),
    .first_err_addr_o(a_first), .obi_req_o(a_req), .obi_gnt_i(a_gnt),
    .obi_addr_o(a_addr), .obi_we_o(a_we), .obi_be_o(a_be), .obi_wdata_o(a_wdata),
    .obi_rvalid_i(a_rvalid), .obi_rdata_i(a_rdata));

  obi_traffic_gen #(.NUM_WORDS(N), .MAX_OUTSTANDING(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .mode_i(b_mode), .pattern_i(b_pat),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_count_o(b_err),
    .first_err_addr_o(b_first), .obi_req_o(b_req), .obi_gnt_i(b_gnt),
    .obi_addr_o(b_addr), .obi_we_o(b_we), .obi_be_o(b_be), .obi_wdata_o(b_wdata),
    .obi_rvalid_i(b_rvalid), .obi_rdata_i(b_rdata));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] p, input int i);
    logic [31:0] ad;
    ad = 32'(i * 4);
    case (p)
      2'd0:    return SEED;
      2'd1:    return SEED + 32'(i);
      2'd2:    return SEED ^ ad;
      default: return ~SEED;
    endcase
  endfunction

  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } txn_t;
  typedef struct { int due; logic [31:0] rdata; bit stale; } rsp_t;

  txn_t        exp_q[$];
  rsp_t        pend_a[$];
  int          pend_b[$];
  logic [31:0] mem [0:N-1];
  logic [7:0]  corrupt_mask = 8'h00;
  bit          rand_gnt = 1'b0;
  int          lat_min = 1, lat_max = 1;
  int          cyc = 0;
  int          out_a = 0, a_grants = 0, a_rd_grants = 0, a_rsps = 0, a_done_cnt = 0;
  int          a_first_g = 0, a_last_g = 0;
  int          out_b = 0, b_grants = 0, b_last_g = 0, b_done_cnt = 0;

  rsp_t        ra;
  txn_t        ta;
  int          idx;
  logic [31:0] rd;

  // Slave for instance A: drives gnt/rvalid on the falling edge, checks every
  // presented request against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      foreach (pend_a[i]) pend_a[i].stale = 1'b1;
      out_a = 0;
    end
    if (a_rvalid && pend_a.size() > 0) begin
      ra = pend_a.pop_front();
      if (!ra.stale) begin out_a--; a_rsps++; end
    end
    if (a_done) a_done_cnt++;
    if (!rst) begin
      check("a_outstanding_le_2", 64'(out_a <= 2), 64'd1);
      if (out_a == 2) check("a_req_at_max", 64'(a_req), 64'd0);
      if (a_req) begin
        if (exp_q.size() == 0) check("a_unexpected_req", 64'(a_req), 64'd0);
        else begin
          ta = exp_q[0];
          check("a_addr", 64'(a_addr), 64'(ta.addr));
          check("a_we", 64'(a_we), 64'(ta.we));
          if (ta.we) check("a_wdata", 64'(a_wdata), 64'(ta.data));
        end
      end
    end
    if (pend_a.size() > 0 && pend_a[0].due <= cyc) begin
      a_rvalid = 1'b1;
      a_rdata  = pend_a[0].rdata;
    end else begin
      a_rvalid = 1'b0;
      a_rdata  = 32'h0;
    end
    a_gnt = rand_gnt ? ($urandom_range(0, 99) < 30) : 1'b1;
    if (a_req && a_gnt && !rst) begin
      a_grants++;
      if (a_grants == 1) a_first_g = cyc;
      a_last_g = cyc;
      out_a++;
      if (exp_q.size() > 0) ta = exp_q.pop_front();
      idx = int'(a_addr[4:2]);
      if (a_we) begin
        mem[idx] = a_wdata;
        rd = 32'hBAD0BAD0;
      end else begin
        a_rd_grants++;
        rd = mem[idx] ^ (corrupt_mask[idx] ? 32'h0000_0100 : 32'h0);
      end
      pend_a.push_back('{due: cyc + $urandom_range(lat_min, lat_max), rdata: rd, stale: 1'b0});
    end
  end

  // Slave for instance B: grant tied high, rvalid two edges after each grant.
  always @(negedge clk) begin
    if (rst) begin pend_b.delete(); out_b = 0; end
    if (b_rvalid && pend_b.size() > 0) begin
      void'(pend_b.pop_front());
      out_b--;
    end
    if (b_done) b_done_cnt++;
    if (out_b >= 1 && !rst) check("b_req_while_outstanding", 64'(b_req), 64'd0);
    b_rvalid = (pend_b.size() > 0 && pend_b[0] <= cyc);
    b_rdata  = 32'h0;
    b_gnt    = 1'b1;
    if (b_req && !rst) begin
      b_grants++;
      if (b_grants > 1) check("b_grant_gap", 64'(cyc - b_last_g), 64'd3);
      b_last_g = cyc;
      check("b_addr", 64'(b_addr), 64'((b_grants - 1) * 4));
      check("b_we", 64'(b_we), 64'd1);
      check("b_wdata", 64'(b_wdata), 64'(SEED));
      out_b++;
      pend_b.push_back(cyc + 2);
    end
  end

  task automatic run_a(input logic [1:0] mode, input logic [1:0] pat);
    a_grants = 0; a_rd_grants = 0; a_rsps = 0; a_done_cnt = 0;
    if (mode != 2'd1)
      for (int i = 0; i < N; i++) exp_q.push_back('{addr: 32'(i*4), we: 1'b1, data: exp_data(pat, i)});
    if (mode != 2'd0)
      for (int i = 0; i < N; i++) exp_q.push_back('{addr: 32'(i*4), we: 1'b0, data: 32'h0});
    @(posedge clk); #1;
    a_mode = mode; a_pat = pat; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int k = 0;
    while (!a_done && k < budget) begin @(negedge clk); k++; end
    check(tag, 64'(k < budget), 64'd1);
  endtask

  task automatic finish_a(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(a_done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(a_busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    a_start = 1'b0; a_mode = 2'd0; a_pat = 2'd0;
    b_start = 1'b0; b_mode = 2'd0; b_pat = 2'd0;
    a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0;
    b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0;
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk); #1;
    check("rst_req", 64'(a_req), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_pass", 64'(a_pass), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_first", 64'(a_first), 64'd0);
    check("rst_addr", 64'(a_addr), 64'd0);
    check("rst_we", 64'(a_we), 64'd0);
    check("rst_wdata", 64'(a_wdata), 64'd0);
    check("rst_be", 64'(a_be), 64'hF);
    check("rst_b_req", 64'(b_req), 64'd0);
    check("rst_b_be", 64'(b_be), 64'hF);
    rst = 1'b0;

    // Write then readback, pattern SEED+i, grant always, rvalid next cycle.
    run_a(2'd2, 2'd1);
    check("t1_busy", 64'(a_busy), 64'd1);
    wait_done_a("t1_timeout", 200);
    check("t1_pass", 64'(a_pass), 64'd1);
    check("t1_err", 64'(a_err), 64'd0);
    check("t1_grants", 64'(a_grants), 64'd16);
    check("t1_span", 64'(a_last_g - a_first_g), 64'd17);
    finish_a("t1");
    check("t1_rsps", 64'(a_rsps), 64'd16);
    check("t1_pass_hold", 64'(a_pass), 64'd1);

    // Readback corrupts word 3.
    corrupt_mask = 8'h08;
    run_a(2'd2, 2'd1);
    wait_done_a("t2_timeout", 200);
    check("t2_err", 64'(a_err), 64'd1);
    check("t2_first", 64'(a_first), 64'h0C);
    check("t2_pass", 64'(a_pass), 64'd0);
    finish_a("t2");

    // Upper four words corrupted, mode 3 behaves as mode 2.
    corrupt_mask = 8'hF0;
    run_a(2'd3, 2'd0);
    wait_done_a("t2b_timeout", 200);
    check("t2b_err", 64'(a_err), 64'd4);
    check("t2b_first", 64'(a_first), 64'h10);
    check("t2b_pass", 64'(a_pass), 64'd0);
    finish_a("t2b");

    // Random 30% grant, response latency 1..4.
    corrupt_mask = 8'h00; rand_gnt = 1'b1; lat_min = 1; lat_max = 4;
    run_a(2'd2, 2'd3);
    wait_done_a("t3_timeout", 3000);
    check("t3_pass", 64'(a_pass), 64'd1);
    check("t3_rsps", 64'(a_rsps), 64'd16);
    check("t3_pending", 64'(pend_a.size()), 64'd0);
    finish_a("t3");
    rand_gnt = 1'b0;

    // One transaction in flight on instance B, write-only.
    b_grants = 0; b_done_cnt = 0;
    @(posedge clk); #1;
    b_mode = 2'd0; b_pat = 2'd0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    k = 0;
    while (!b_done && k < 300) begin @(negedge clk); k++; end
    check("t4_timeout", 64'(k < 300), 64'd1);
    check("t4_pass", 64'(b_pass), 64'd1);
    check("t4_err", 64'(b_err), 64'd0);
    repeat (2) @(negedge clk);
    check("t4_grants", 64'(b_grants), 64'd8);
    check("t4_done_pulses", 64'(b_done_cnt), 64'd1);

    // Reset in the middle of the read phase, after a mismatch was counted.
    corrupt_mask = 8'h01; lat_min = 2; lat_max = 2;
    run_a(2'd2, 2'd1);
    k = 0;
    while (a_rd_grants < 4 && k < 300) begin @(posedge clk); #1; k++; end
    check("t5_reach_4_reads", 64'(k < 300), 64'd1);
    check("t5_err_before", 64'(a_err), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_req", 64'(a_req), 64'd0);
    check("t5_busy", 64'(a_busy), 64'd0);
    check("t5_err", 64'(a_err), 64'd0);
    check("t5_first", 64'(a_first), 64'd0);
    rst = 1'b0;
    k = 0;
    while (pend_a.size() > 0 && k < 50) begin @(negedge clk); k++; end
    check("t5_stale_drained", 64'(pend_a.size()), 64'd0);
    check("t5_err_idle", 64'(a_err), 64'd0);

    // Read-only against SEED^addr; a start pulse mid-run must be ignored.
    corrupt_mask = 8'h00; lat_min = 1; lat_max = 3;
    for (int i = 0; i < N; i++) mem[i] = SEED ^ 32'(i * 4);
    run_a(2'd1, 2'd2);
    repeat (3) @(posedge clk); #1;
    a_mode = 2'd0; a_pat = 2'd0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_done_a("t6_timeout", 300);
    check("t6_pass", 64'(a_pass), 64'd1);
    check("t6_err", 64'(a_err), 64'd0);
    check("t6_grants", 64'(a_grants), 64'd8);
    finish_a("t6");
    check("t6_rsps", 64'(a_rsps), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
